capture_controller: RTL and testbench

- Sequences one oscilloscope acquisition. Decimates the ADC sample stream by the user-set rate (count_adc) and writes samples into a circular capture RAM.
- Fills a pre-trigger window, then waits for a rising crossing of the user trigger level, with an auto-trigger timeout.
- Completes the post-trigger window, then hands the frozen buffer to the display path until the display acknowledges.
- Sits between the ADC interface, the user-interface block (trigger, count_adc) and the waveform display reader.

---
 rtl/capture_controller.sv | 169 ++++++++++++++++
 tb/tb_capture_controller.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_controller.sv
// capture_controller: sequences one scope acquisition into a circular RAM.
// Decimates the ADC stream, fills a pre-trigger window, triggers, completes the frame.
module capture_controller #(
    parameter int ADDR_W       = 10,
    parameter int PRE_TRIG     = 256,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       adc_data,
    input  logic              adc_valid,
    input  logic [11:0]       trigger,
    input  logic [11:0]       count_adc,
    input  logic              run,
    input  logic              arm,
    input  logic              rd_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              capture_done,
    output logic              frame_valid,
    output logic              auto_trig,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRETRIG,
        ARMED,
        POST,
        DONE
    } state_t;

    localparam int                POST_N    = (1 << ADDR_W) - PRE_TRIG - 1;
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_N - 1);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam logic [31:0]       TIMEOUT   = 32'(AUTO_TIMEOUT);

    state_t            state;
    state_t            nxt;
    logic [11:0]       dec_cnt;
    logic [11:0]       div_m1;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] cnt;
    logic [31:0]       to_cnt;
    logic [31:0]       to_next;
    logic [11:0]       prev_sample;
    logic              fin;
    logic              busy_s;
    logic              take;
    logic              real_trig;
    logic              force_trig;
    logic              trig_ev;
    logic              pre_done;
    logic              enter_pre;

    always_comb begin
        busy_s     = (state == PRETRIG) || (state == ARMED) || (state == POST);
        div_m1     = (count_adc == 12'd0) ? 12'd0 : count_adc - 12'd1;
        // fin blocks further takes while the last POST write drains
        take       = busy_s && adc_valid && (dec_cnt >= div_m1) && !fin;
        real_trig  = (prev_sample < trigger) && (adc_data >= trigger);
        to_next    = to_cnt + 32'd1;
        force_trig = (AUTO_TIMEOUT != 0) && (to_next == TIMEOUT);
        trig_ev    = (state == ARMED) && take && (real_trig || force_trig);
        pre_done   = (PRE_TRIG == 0) || (take && (cnt == PRE_LAST));
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (arm || run) nxt = PRETRIG;
            end
            PRETRIG: begin
                if (pre_done) nxt = ARMED;
            end
            ARMED: begin
                if (trig_ev) nxt = POST;
            end
            POST: begin
                if (fin) nxt = DONE;
            end
            DONE: begin
                if (arm || (rd_done && run)) nxt = PRETRIG;
                else if (rd_done) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign enter_pre   = (nxt == PRETRIG) && (state != PRETRIG);
    assign busy        = busy_s;
    assign frame_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            dec_cnt      <= '0;
            ptr          <= '0;
            cnt          <= '0;
            to_cnt       <= '0;
            prev_sample  <= '0;
            fin          <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            start_addr   <= '0;
            trig_addr    <= '0;
            auto_trig    <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            state        <= nxt;
            wr_en        <= take;
            capture_done <= (nxt == DONE) && (state != DONE);

            if (take) begin
                wr_data     <= adc_data;
                wr_addr     <= ptr;
                prev_sample <= adc_data;
            end

            if (enter_pre) begin
                dec_cnt <= '0;
            end else if (busy_s && adc_valid) begin
                dec_cnt <= (dec_cnt >= div_m1) ? 12'd0 : dec_cnt + 12'd1;
            end

            if (enter_pre) begin
                ptr <= '0;
            end else if (take) begin
                ptr <= ptr + ONE;
            end

            if (enter_pre) begin
                cnt <= '0;
            end else if (take) begin
                if (state == PRETRIG) cnt <= pre_done ? '0 : cnt + ONE;
                else if (state == ARMED) cnt <= '0;
                else cnt <= cnt + ONE;
            end

            if (enter_pre) begin
                fin <= 1'b0;
            end else if (trig_ev && (POST_N == 0)) begin
                fin <= 1'b1;
            end else if ((state == POST) && take && (cnt == POST_LAST)) begin
                fin <= 1'b1;
            end

            if (enter_pre) begin
                to_cnt <= '0;
            end else if ((state == ARMED) && take) begin
                to_cnt <= to_next;
            end

            if (trig_ev) begin
                trig_addr  <= ptr;
                start_addr <= ptr - PRE_OFS;
                auto_trig  <= !real_trig;
            end
        end
    end

endmodule

// File: tb/tb_capture_controller.sv
// Self-checking bench for capture_controller: vector table, hand-written
// corner sequences and randomized captures against a frame-level model.
module tb_capture_controller;

    localparam int AW    = 4;
    localparam int PT    = 4;
    localparam int AT    = 8;
    localparam int DEPTH = 16;
    localparam int POSTN = DEPTH - PT - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [11:0]   adc_data = '0;
    logic          adc_valid = 1'b0;
    logic [11:0]   trigger = 12'd100;
    logic [11:0]   count_adc = 12'd1;
    logic          run = 1'b0;
    logic          arm = 1'b0;
    logic          rd_done = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] trig_addr;
    logic          capture_done;
    logic          frame_valid;
    logic          auto_trig;
    logic          busy;

    capture_controller #(
        .ADDR_W(AW),
        .PRE_TRIG(PT),
        .AUTO_TIMEOUT(AT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .adc_data(adc_data),
        .adc_valid(adc_valid),
        .trigger(trigger),
        .count_adc(count_adc),
        .run(run),
        .arm(arm),
        .rd_done(rd_done),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start_addr(start_addr),
        .trig_addr(trig_addr),
        .capture_done(capture_done),
        .frame_valid(frame_valid),
        .auto_trig(auto_trig),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   wq_addr[$];
    int   wq_data[$];
    int   done_cnt = 0;
    logic v_last = 1'b0;

    typedef struct {
        int cnt;
        int n;
        int exp_wr;
        int exp_last;
    } dec_vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({wr_en, wr_addr, wr_data, start_addr, trig_addr,
                     capture_done, frame_valid, auto_trig, busy});
    endfunction

    always @(posedge clk) v_last <= adc_valid;

    always @(negedge clk) begin
        if (wr_en) begin
            wq_addr.push_back(int'(wr_addr));
            wq_data.push_back(int'(wr_data));
            chk("wr_latency", int'(v_last), 1);
            chk("wr_in_busy", int'(busy), 1);
        end
        if (capture_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
    endtask

    task automatic strobe(input int d, input int gap);
        adc_data  = 12'(d);
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_rd();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        arm = 1'b0;
        rd_done = 1'b0;
        adc_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        clear();
    endtask

    task automatic feed(input int d, input int gap, input int max);
        int g;
        g = 0;
        while (!frame_valid && g < max) begin
            strobe(d, gap);
            g++;
        end
    endtask

    task automatic random_capture();
        int div;
        int d;
        int g;
        int kt;
        int total;
        bit is_real;
        int strobes[$];
        int takes[$];
        count_adc = 12'($urandom_range(0, 3));
        trigger   = 12'($urandom_range(50, 4000));
        div = (count_adc == 12'd0) ? 1 : int'(count_adc);
        clear();
        pulse_arm();
        g = 0;
        while (!frame_valid && g < 2000) begin
            d = int'(trigger) + int'($urandom_range(0, 60)) - 30;
            strobes.push_back(d);
            strobe(d, int'($urandom_range(0, 2)));
            g++;
        end
        tick();
        chk("rand_done", int'(frame_valid), 1);
        for (int s = 0; s < strobes.size(); s++)
            if ((s + 1) % div == 0) takes.push_back(strobes[s]);
        kt = -1;
        is_real = 1'b0;
        for (int k = PT; k < takes.size(); k++) begin
            is_real = (takes[k-1] < int'(trigger)) && (takes[k] >= int'(trigger));
            if (is_real || (k - PT + 1 == AT)) begin
                kt = k;
                break;
            end
        end
        chk("rand_trig_found", int'(kt >= 0), 1);
        if (kt >= 0) begin
            total = kt + 1 + POSTN;
            chk("rand_nwr", wq_addr.size(), total);
            for (int i = 0; i < total && i < wq_addr.size(); i++) begin
                chk("rand_wr_addr", wq_addr[i], i % DEPTH);
                chk("rand_wr_data", wq_data[i], takes[i]);
            end
            chk("rand_trig_addr", int'(trig_addr), kt % DEPTH);
            chk("rand_start_addr", int'(start_addr), (kt - PT + DEPTH) % DEPTH);
            chk("rand_auto", int'(auto_trig), is_real ? 0 : 1);
            chk("rand_done_pulse", done_cnt, 1);
        end
        pulse_rd();
    endtask

    initial begin
        dec_vec_t tbl[6];
        int d;
        int n0;

        tbl[0] = '{4, 64, 16, 63};
        tbl[1] = '{0, 20, 20, 19};
        tbl[2] = '{1, 15, 15, 14};
        tbl[3] = '{3, 30, 10, 29};
        tbl[4] = '{5, 12, 2, 9};
        tbl[5] = '{2, 7, 3, 5};

        tick();
        tick();
        chk("reset_outs", outs(), 0);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", int'(busy), 0);

        for (int t = 0; t < 6; t++) begin
            do_reset();
            count_adc = 12'(tbl[t].cnt);
            pulse_arm();
            for (int i = 0; i < tbl[t].n; i++) strobe(i, 0);
            tick();
            tick();
            chk("dec_nwr", wq_addr.size(), tbl[t].exp_wr);
            chk("dec_last", (wq_data.size() > 0) ? wq_data[$] : -1, tbl[t].exp_last);
        end

        do_reset();
        count_adc = 12'd8;
        pulse_arm();
        for (int i = 0; i < 13; i++) strobe(i, 0);
        count_adc = 12'd2;
        strobe(99, 0);
        strobe(98, 0);
        tick();
        tick();
        chk("dec_shrink_nwr", wq_addr.size(), 2);
        chk("dec_shrink_data", (wq_data.size() > 1) ? wq_data[1] : -1, 99);

        do_reset();
        count_adc = 12'd1;
        trigger = 12'd100;
        arm = 1'b1;
        adc_data = 12'd90;
        adc_valid = 1'b1;
        tick();
        arm = 1'b0;
        adc_valid = 1'b0;
        tick();
        tick();
        d = 92;
        while (!frame_valid && d < 400) begin
            strobe(d, 2);
            d += 2;
        end
        tick();
        chk("ramp_done", int'(frame_valid), 1);
        chk("ramp_nwr", wq_addr.size(), 16);
        chk("ramp_first_addr", (wq_addr.size() > 0) ? wq_addr[0] : -1, 0);
        chk("ramp_trig_addr", int'(trig_addr), 4);
        chk("ramp_trig_data", (wq_data.size() > 4) ? wq_data[4] : -1, 100);
        chk("ramp_start_addr", int'(start_addr), 0);
        chk("ramp_auto", int'(auto_trig), 0);
        chk("ramp_done_pulse", done_cnt, 1);

        pulse_rd();
        clear();
        pulse_arm();
        feed(50, 0, 100);
        tick();
        tick();
        chk("auto_nwr", wq_addr.size(), 23);
        chk("auto_trig_addr", int'(trig_addr), 11);
        chk("auto_start_addr", int'(start_addr), 7);
        chk("auto_flag", int'(auto_trig), 1);
        chk("auto_wrap_addr", (wq_addr.size() > 22) ? wq_addr[22] : -1, 6);
        chk("auto_done_pulse", done_cnt, 1);

        pulse_rd();
        clear();
        pulse_arm();
        strobe(130, 1);
        strobe(125, 1);
        strobe(122, 1);
        strobe(121, 1);
        strobe(120, 1);
        strobe(110, 1);
        strobe(105, 1);
        tick();
        tick();
        chk("fall_nwr", wq_addr.size(), 7);
        chk("fall_no_trig", int'(frame_valid), 0);
        chk("fall_busy", int'(busy), 1);
        strobe(99, 1);
        strobe(100, 1);
        feed(200, 1, 100);
        tick();
        chk("level_trig_addr", int'(trig_addr), 8);
        chk("level_start_addr", int'(start_addr), 4);
        chk("level_auto", int'(auto_trig), 0);
        chk("level_trig_data", (wq_data.size() > 8) ? wq_data[8] : -1, 100);
        chk("level_nwr", wq_addr.size(), 20);

        n0 = wq_addr.size();
        repeat (5) tick();
        chk("done_hold_fv", int'(frame_valid), 1);
        chk("done_hold_nwr", wq_addr.size(), n0);
        chk("done_hold_trig", int'(trig_addr), 8);
        pulse_rd();
        chk("rd_to_idle_fv", int'(frame_valid), 0);
        chk("rd_to_idle_busy", int'(busy), 0);
        strobe(10, 0);
        strobe(11, 0);
        tick();
        tick();
        chk("idle_no_writes", wq_addr.size(), n0);
        clear();
        pulse_arm();
        chk("arm_restart", int'(busy), 1);
        pulse_rd();
        chk("rd_ignored_busy", int'(busy), 1);
        strobe(10, 0);
        strobe(11, 0);
        pulse_arm();
        strobe(12, 0);
        tick();
        tick();
        chk("arm_busy_nwr", wq_addr.size(), 3);
        chk("arm_busy_addr", (wq_addr.size() > 2) ? wq_addr[2] : -1, 2);
        run = 1'b1;
        feed(50, 0, 100);
        tick();
        chk("run_done", int'(frame_valid), 1);
        pulse_rd();
        chk("run_rearm", int'(busy), 1);

        clear();
        for (int i = 0; i < 15; i++) strobe(50, 0);
        chk("post_reached", int'(trig_addr), 11);
        chk("post_not_done", int'(frame_valid), 0);
        done_cnt = 0;
        rst = 1'b1;
        adc_data = 12'd50;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
        chk("rst_mid_outs", outs(), 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("rst_run_restart", int'(busy), 1);
        chk("rst_no_done", done_cnt, 0);
        clear();
        strobe(7, 0);
        tick();
        tick();
        chk("rst_first_addr", (wq_addr.size() > 0) ? wq_addr[0] : -1, 0);
        chk("rst_first_data", (wq_data.size() > 0) ? wq_data[0] : -1, 7);

        run = 1'b0;
        do_reset();
        for (int r = 0; r < 12; r++) random_capture();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
